// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the instruction-fetch stage.
package pipe_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_OUT = 2'd2,
    FLUSH    = 2'd3
  } fetch_state_t;

  localparam logic [XLEN-1:0] INSTR_BUBBLE     = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Sequential PC step; wraps naturally at 2^32.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a req/ack imem port, feeds IF/ID.
// Optional FETCH_PERF_CNT_EN adds instruction-delivered and redirect counters.
module if_fetch_unit
  import pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pcplus4
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  hold_q, hold_d;
  logic         req_q;
  logic         valid_q, valid_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  opc_q, opc_d;
  logic [31:0]  opc4_q, opc4_d;
  logic         load;
  logic [31:0]  load_instr;

  // Next-state, PC/address and output-slot logic; redirect dominates everything.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    addr_d     = addr_q;
    hold_d     = hold_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    opc_d      = opc_q;
    opc4_d     = opc4_q;
    load       = 1'b0;
    load_instr = INSTR_BUBBLE;

    case (state_q)
      IDLE: begin
        state_d = FETCH;
        if (redirect) begin
          pc_d   = redirect_pc;
          addr_d = redirect_pc;
        end else begin
          addr_d = pc_q;
        end
      end
      FETCH: begin
        if (redirect) begin
          pc_d = redirect_pc;
          // An unacked request cannot be withdrawn; drain it in FLUSH.
          if (imem_ack) addr_d = redirect_pc;
          else          state_d = FLUSH;
        end else if (imem_ack) begin
          pc_d = pc_inc(pc_q);
          if (!valid_q || !stall) begin
            load       = 1'b1;
            load_instr = imem_rdata;
            addr_d     = pc_inc(pc_q);
          end else begin
            hold_d  = imem_rdata;
            state_d = WAIT_OUT;
          end
        end
      end
      WAIT_OUT: begin
        if (redirect) begin
          pc_d    = redirect_pc;
          addr_d  = redirect_pc;
          state_d = FETCH;
        end else if (!stall) begin
          // imem_addr still names the held word; pc already points past it.
          load       = 1'b1;
          load_instr = hold_q;
          addr_d     = pc_q;
          state_d    = FETCH;
        end
      end
      FLUSH: begin
        if (redirect) pc_d = redirect_pc;
        if (imem_ack) begin
          addr_d  = redirect ? redirect_pc : pc_q;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase

    if (redirect) begin
      valid_d = 1'b0;
      instr_d = INSTR_BUBBLE;
      opc_d   = 32'h0;
      opc4_d  = 32'h0;
      hold_d  = INSTR_BUBBLE;
    end else if (load) begin
      valid_d = 1'b1;
      instr_d = load_instr;
      opc_d   = addr_q;
      opc4_d  = pc_inc(addr_q);
    end else if (valid_q && !stall) begin
      valid_d = 1'b0;
      instr_d = INSTR_BUBBLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      hold_q  <= INSTR_BUBBLE;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      instr_q <= INSTR_BUBBLE;
      opc_q   <= 32'h0;
      opc4_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      hold_q  <= hold_d;
      req_q   <= (state_d == FETCH) || (state_d == FLUSH);
      valid_q <= valid_d;
      instr_q <= instr_d;
      opc_q   <= opc_d;
      opc4_q  <= opc4_d;
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign if_valid   = valid_q;
  assign if_instr   = instr_q;
  assign if_pc      = opc_q;
  assign if_pcplus4 = opc4_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= 32'h0;
      flush_cnt_q <= 32'h0;
    end else begin
      if (valid_q && !stall) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect)          flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed plus randomized bench for if_fetch_unit with an in-order delivery scoreboard.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pcplus4;
  logic        ack_en;

  int total = 0;
  int bad   = 0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_flush_cnt;
`endif

  if_fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_pcplus4  (if_pcplus4)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory content is a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  assign imem_ack   = imem_req && ack_en;
  assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_DEAD;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(if_valid), 32'd0);
    chk({tag, "_instr"}, if_instr, 32'h0);
    chk({tag, "_pc"}, if_pc, 32'h0);
    chk({tag, "_pc4"}, if_pcplus4, 32'h0);
    chk({tag, "_req"}, 32'(imem_req), 32'd0);
    chk({tag, "_addr"}, imem_addr, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] exp_pc;
    logic [31:0] r;
    logic        pend;
    logic [31:0] pend_addr;
    int          delivered;

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ack_en = 1'b1;
    #3;
    chk_reset("por");
    @(negedge clk); rst_n = 1'b1;

    // Zero-wait streaming from RESET_PC
    step();
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    for (int k = 2; k <= 3; k++) begin
      step();
      chk("stream_valid", 32'(if_valid), 32'd1);
      chk("stream_pc", if_pc, 32'(4 * (k - 2)));
      chk("stream_instr", if_instr, mem_word(32'(4 * (k - 2))));
      chk("stream_addr", imem_addr, 32'(4 * (k - 1)));
    end

    // Stall for three edges while word@8 returns
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", if_pc, 32'h4);
      chk("stall_valid", 32'(if_valid), 32'd1);
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_addr", imem_addr, 32'h8);
    end
    stall = 1'b0;
    step();
    chk("rel_pc", if_pc, 32'h8);
    chk("rel_instr", if_instr, mem_word(32'h8));
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, 32'hC);
    step();
    chk("rel_next_pc", if_pc, 32'hC);
    chk("rel_next_valid", 32'(if_valid), 32'd1);

    // Redirect with the same-cycle ack
    redirect = 1'b1; redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("rd1_valid", 32'(if_valid), 32'd0);
    chk("rd1_instr", if_instr, 32'h0);
    chk("rd1_addr", imem_addr, 32'h100);
    step();
    chk("rd1_pc", if_pc, 32'h100);
    chk("rd1_instr2", if_instr, mem_word(32'h100));

    // Redirect while a request to 0x10 is outstanding
    redirect = 1'b1; redirect_pc = 32'h10;
    step();
    redirect = 1'b0;
    chk("rd2_addr0", imem_addr, 32'h10);
    ack_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h200;
    step();
    redirect = 1'b0;
    chk("flush_addr_a", imem_addr, 32'h10);
    chk("flush_req_a", 32'(imem_req), 32'd1);
    chk("flush_valid_a", 32'(if_valid), 32'd0);
    step();
    chk("flush_addr_b", imem_addr, 32'h10);
    chk("flush_valid_b", 32'(if_valid), 32'd0);
    ack_en = 1'b1;
    step();
    chk("flush_done_addr", imem_addr, 32'h200);
    chk("flush_done_valid", 32'(if_valid), 32'd0);
    chk("flush_done_instr", if_instr, 32'h0);
    step();
    chk("rd2_pc", if_pc, 32'h200);
    chk("rd2_valid", 32'(if_valid), 32'd1);
    chk("rd2_instr", if_instr, mem_word(32'h200));

    // PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", if_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4", if_pcplus4, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    step();
    chk("wrap_next_pc", if_pc, 32'h0);

    // Async reset in FETCH
    #2; rst_n = 1'b0; #1;
    chk_reset("rst_fetch");
    @(negedge clk); rst_n = 1'b1;
    step();
    chk("rst1_req", 32'(imem_req), 32'd1);
    chk("rst1_addr", imem_addr, 32'h0);
    step();
    chk("rst1_pc", if_pc, 32'h0);
    stall = 1'b1;
    step();
    chk("wait_req", 32'(imem_req), 32'd0);
    // Async reset in WAIT_OUT
    #2; rst_n = 1'b0; #1;
    chk_reset("rst_wait");
    stall = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Randomized run against an in-order delivery scoreboard
    exp_pc    = 32'h0;
    pend      = 1'b0;
    pend_addr = 32'h0;
    delivered = 0;
    for (int c = 0; c < 1500; c++) begin
      step();
      if (!if_valid) chk("rnd_bubble", if_instr, 32'h0);
      else           chk("rnd_pc4", if_pcplus4, if_pc + 32'd4);
      if (pend) chk("rnd_addr_stable", imem_addr, pend_addr);
      stall    = ($urandom_range(3) == 0);
      redirect = ($urandom_range(19) == 0);
      r = $urandom();
      redirect_pc = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : {r[31:2], 2'b00};
      ack_en = ($urandom_range(9) < 6);
      if (if_valid && !stall && !redirect) begin
        chk("rnd_pc", if_pc, exp_pc);
        chk("rnd_instr", if_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (redirect) exp_pc = redirect_pc;
      @(negedge clk);
      pend      = imem_req && !imem_ack;
      pend_addr = imem_addr;
    end
    stall = 1'b0; redirect = 1'b0;
    chk("rnd_progress", 32'(delivered >= 100), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
